// File: rtl/grf_wport_arbiter_if.sv
// Write-port sharing bus: primary writeback, secondary queue, register-file port and hazard outputs.
interface grf_wport_arbiter_if;
  logic        p_we;
  logic [4:0]  p_a3;
  logic [31:0] p_wd;
  logic        s_valid;
  logic [4:0]  s_a3;
  logic [31:0] s_wd;
  logic        s_ready;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] pend_mask;
  logic        stall_req;
  logic [3:0]  fifo_count;

  modport slave (
    input  p_we, p_a3, p_wd, s_valid, s_a3, s_wd,
    output s_ready, grf_a3, grf_wd, pend_mask, stall_req, fifo_count
  );

  modport master (
    output p_we, p_a3, p_wd, s_valid, s_a3, s_wd,
    input  s_ready, grf_a3, grf_wd, pend_mask, stall_req, fifo_count
  );
endinterface

// File: rtl/grf_wport_arbiter.sv
// Register-file write-port arbiter: primary writeback wins, secondary writes queue in a FIFO
// and drain into idle cycles; overwritten queued entries are squashed, starvation raises stall_req.
module grf_wport_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic               clk,
  input logic               reset,
  grf_wport_arbiter_if.slave bus
);
  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         SW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [3:0]     count;
  logic [DEPTH-1:0] vld;
  logic [4:0]     e_a3 [DEPTH];
  logic [31:0]    e_wd [DEPTH];
  logic [SW-1:0]  starve_cnt, starve_next;
  logic           stall_q;

  logic p_eff, s_ready, push, occ, pop, head_live;
  logic [31:0] pend;

  assign p_eff     = bus.p_we && (bus.p_a3 != 5'd0);
  assign s_ready   = (count < DEPTH_C);
  assign push      = bus.s_valid && s_ready && (bus.s_a3 != 5'd0);
  assign occ       = (count != 4'd0);
  assign pop       = occ && !p_eff;
  // queued data is held off the port while reset is applied so dropped writes never escape
  assign head_live = occ && vld[rd_ptr] && !reset;

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i]) pend[e_a3[i]] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  always_comb begin
    if (pop || !occ)
      starve_next = '0;
    else if (starve_cnt < LIMIT_C)
      starve_next = starve_cnt + 1'b1;
    else
      starve_next = starve_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      vld        <= '0;
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      if (p_eff) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (vld[i] && (e_a3[i] == bus.p_a3)) vld[i] <= 1'b0;
        end
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      // the push slot is never the head of a non-full queue, so this cannot collide with the pop
      if (push) begin
        vld[wr_ptr]  <= 1'b1;
        e_a3[wr_ptr] <= bus.s_a3;
        e_wd[wr_ptr] <= bus.s_wd;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      starve_cnt <= starve_next;
      stall_q    <= (starve_next == LIMIT_C);
    end
  end

  always_comb begin
    bus.grf_a3 = 5'd0;
    bus.grf_wd = 32'd0;
    if (p_eff) begin
      bus.grf_a3 = bus.p_a3;
      bus.grf_wd = bus.p_wd;
    end else if (head_live) begin
      bus.grf_a3 = e_a3[rd_ptr];
      bus.grf_wd = e_wd[rd_ptr];
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.pend_mask  = pend;
  assign bus.stall_req  = stall_q;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Bench for grf_wport_arbiter: queue-based reference model checked every cycle plus directed literal checks.
module tb_grf_wport_arbiter;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grf_wport_arbiter_if bus();

  grf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd;
    bit          live;
  } ent_t;

  ent_t        q[$];
  int          wait_cnt = 0;
  bit          m_stall  = 0;
  logic [31:0] rf_dut [32];

  initial for (int i = 0; i < 32; i++) rf_dut[i] = 32'd0;

  // reference model: outputs checked at negedge, state advanced at posedge
  initial begin : model
    logic        peff;
    logic [4:0]  ea3;
    logic [31:0] ewd;
    logic [31:0] epend;
    int          sz;
    bit          popm;
    ent_t        e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      peff = bus.p_we && (bus.p_a3 != 5'd0);
      ea3 = 5'd0;
      ewd = 32'd0;
      if (peff) begin
        ea3 = bus.p_a3;
        ewd = bus.p_wd;
      end else if (!reset && q.size() > 0 && q[0].live) begin
        ea3 = q[0].a3;
        ewd = q[0].wd;
      end
      epend = 32'd0;
      foreach (q[i]) if (q[i].live) epend = epend | (32'd1 << q[i].a3);
      chk("model_grf_a3", {27'd0, bus.grf_a3}, {27'd0, ea3});
      chk("model_grf_wd", bus.grf_wd, ewd);
      chk("model_s_ready", {31'd0, bus.s_ready}, {31'd0, q.size() < DEPTH});
      chk("model_pend_mask", bus.pend_mask, epend);
      chk("model_fifo_count", {28'd0, bus.fifo_count}, 32'(q.size()));
      chk("model_stall_req", {31'd0, bus.stall_req}, {31'd0, m_stall});
      if (bus.grf_a3 != 5'd0) rf_dut[bus.grf_a3] = bus.grf_wd;
      @(posedge clk);
      cyc++;
      if (reset) begin
        q.delete();
        wait_cnt = 0;
        m_stall  = 0;
      end else begin
        sz   = q.size();
        popm = !peff && sz > 0;
        if (peff) foreach (q[i]) if (q[i].a3 == bus.p_a3) q[i].live = 0;
        if (popm) void'(q.pop_front());
        if (bus.s_valid && sz < DEPTH && bus.s_a3 != 5'd0) begin
          e.a3 = bus.s_a3; e.wd = bus.s_wd; e.live = 1;
          q.push_back(e);
        end
        if (popm || sz == 0) wait_cnt = 0;
        else if (wait_cnt < STARVE_LIMIT) wait_cnt++;
        m_stall = (wait_cnt == STARVE_LIMIT);
      end
    end
  end

  task automatic drive(input logic pwe, input logic [4:0] pa3, input logic [31:0] pwd,
                       input logic sv, input logic [4:0] sa3, input logic [31:0] swd);
    bus.p_we = pwe; bus.p_a3 = pa3; bus.p_wd = pwd;
    bus.s_valid = sv; bus.s_a3 = sa3; bus.s_wd = swd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick(); tick();
    reset = 1'b0;

    // 1: post-reset idle
    idle();
    chk("rst_grf_a3", {27'd0, bus.grf_a3}, 32'd0);
    chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd1);
    chk("rst_pend", bus.pend_mask, 32'd0);
    chk("rst_count", {28'd0, bus.fifo_count}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall_req}, 32'd0);
    tick();

    // 2: single secondary write, one-cycle latency
    drive(0, 0, 0, 1, 5, 32'h1234);
    chk("t2_no_bypass", {27'd0, bus.grf_a3}, 32'd0);
    tick();
    idle();
    chk("t2_pend", bus.pend_mask, 32'h20);
    chk("t2_grf_a3", {27'd0, bus.grf_a3}, 32'd5);
    chk("t2_grf_wd", bus.grf_wd, 32'h1234);
    tick();
    chk("t2_pend_clr", bus.pend_mask, 32'd0);
    chk("t2_count0", {28'd0, bus.fifo_count}, 32'd0);

    // 3: fill under continuous primary traffic, starvation stall
    for (int i = 0; i < 4; i++) begin
      drive(1, 9, 32'h9999, 1, 5'(i + 1), 32'h100 + 32'(i + 1));
      chk("t3_ready_fill", {31'd0, bus.s_ready}, 32'd1);
      chk("t3_grf_a3", {27'd0, bus.grf_a3}, 32'd9);
      tick();
    end
    drive(1, 9, 32'h9999, 1, 5'd6, 32'h666);
    chk("t3_ready_full", {31'd0, bus.s_ready}, 32'd0);
    chk("t3_count4", {28'd0, bus.fifo_count}, 32'd4);
    chk("t3_pend", bus.pend_mask, 32'h1E);
    for (int i = 0; i < 4; i++) tick();
    chk("t3_stall_early", {31'd0, bus.stall_req}, 32'd0);
    tick();
    chk("t3_stall_set", {31'd0, bus.stall_req}, 32'd1);
    tick();
    chk("t3_stall_hold", {31'd0, bus.stall_req}, 32'd1);
    chk("t3_primary_wins", {27'd0, bus.grf_a3}, 32'd9);
    idle();
    chk("t3_drain_a3", {27'd0, bus.grf_a3}, 32'd1);
    chk("t3_drain_wd", bus.grf_wd, 32'h101);
    tick();
    chk("t3_stall_clr", {31'd0, bus.stall_req}, 32'd0);
    for (int i = 2; i <= 4; i++) begin
      chk("t3_order", {27'd0, bus.grf_a3}, 32'(i));
      tick();
    end
    chk("t3_empty", {28'd0, bus.fifo_count}, 32'd0);

    // 4: WAW squash, then a same-cycle younger push that must survive
    drive(0, 0, 0, 1, 7, 32'hAAAA);
    tick();
    drive(1, 7, 32'hBBBB, 0, 0, 0);
    chk("t4_pend7", bus.pend_mask, 32'h80);
    chk("t4_primary", bus.grf_wd, 32'hBBBB);
    tick();
    idle();
    chk("t4_pend_sq", bus.pend_mask, 32'd0);
    chk("t4_slot_held", {28'd0, bus.fifo_count}, 32'd1);
    chk("t4_silent_pop", {27'd0, bus.grf_a3}, 32'd0);
    tick();
    chk("t4_popped", {28'd0, bus.fifo_count}, 32'd0);
    chk("t4_rf7", rf_dut[7], 32'hBBBB);
    drive(1, 7, 32'hDDDD, 1, 7, 32'hCCCC);
    tick();
    idle();
    chk("t4_young_pend", bus.pend_mask, 32'h80);
    chk("t4_young_wd", bus.grf_wd, 32'hCCCC);
    tick();

    // 5: push while popping at count DEPTH-1 across pointer wrap
    for (int i = 10; i <= 12; i++) begin
      drive(1, 9, 32'h9, 1, 5'(i), 32'hA00 + 32'(i));
      tick();
    end
    for (int i = 13; i <= 15; i++) begin
      drive(0, 0, 0, 1, 5'(i), 32'hA00 + 32'(i));
      chk("t5_pop_a3", {27'd0, bus.grf_a3}, 32'(i - 3));
      chk("t5_pop_wd", bus.grf_wd, 32'hA00 + 32'(i - 3));
      tick();
      chk("t5_count", {28'd0, bus.fifo_count}, 32'd3);
    end
    idle();
    for (int i = 13; i <= 15; i++) begin
      chk("t5_tail_wd", bus.grf_wd, 32'hA00 + 32'(i));
      tick();
    end
    chk("t5_empty", {27'd0, bus.grf_a3}, 32'd0);

    // 7: zero-register push discarded; p_a3=0 primary is not effective
    drive(0, 0, 0, 1, 0, 32'h77);
    tick();
    chk("t7_r0_drop", {28'd0, bus.fifo_count}, 32'd0);
    drive(0, 0, 0, 1, 3, 32'h33);
    tick();
    drive(1, 0, 32'hDEAD, 0, 0, 0);
    chk("t7_p0_a3", {27'd0, bus.grf_a3}, 32'd3);
    chk("t7_p0_wd", bus.grf_wd, 32'h33);
    tick();

    // 6: reset with queued entries drops them
    for (int i = 20; i <= 22; i++) begin
      drive(1, 9, 32'h9, 1, 5'(i), 32'(i));
      tick();
    end
    reset = 1'b1;
    drive(0, 0, 0, 1, 23, 32'h23);
    chk("t6_rst_gate", {27'd0, bus.grf_a3}, 32'd0);
    tick();
    reset = 1'b0;
    idle();
    chk("t6_count", {28'd0, bus.fifo_count}, 32'd0);
    chk("t6_pend", bus.pend_mask, 32'd0);
    chk("t6_stall", {31'd0, bus.stall_req}, 32'd0);
    chk("t6_no_write", {27'd0, bus.grf_a3}, 32'd0);
    tick();
    chk("t6_no_write2", {27'd0, bus.grf_a3}, 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/grf_wport_arbiter.md
Name: grf_wport_arbiter

Overview:
Shares the register file's single write port between the in-order pipeline writeback (primary) and a long-latency unit such as the multiply/divide unit (secondary). Secondary writes are buffered in a small FIFO and drained into idle write-port cycles. The block exports a pending-write mask for the hazard unit, and requests a pipeline stall when the secondary requester is starved. It sits between the W stage and the register file write port (A3/WD).

Parameters:
DEPTH, 4, secondary FIFO entries (power of 2, 2..8)
STARVE_LIMIT, 8, cycles a valid FIFO head may wait before stall_req asserts

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
p_we  input  1  primary (W stage) write request
p_a3  input  5  primary destination register
p_wd  input  32  primary write data
s_valid  input  1  secondary write request
s_a3  input  5  secondary destination register
s_wd  input  32  secondary write data
s_ready  output  1  FIFO can accept; transfer when s_valid&&s_ready
grf_a3  output  5  register-file write address (0 = no write)
grf_wd  output  32  register-file write data
pend_mask  output  32  bit r set iff a valid queued entry targets r
stall_req  output  1  asks pipeline to suppress p_we; registered
fifo_count  output  4  number of valid FIFO entries (debug)

Behaviour:
- Primary is effective when p_we=1 and p_a3!=0. Secondary push occurs when s_valid && s_ready. Pushes with s_a3==0 are accepted and discarded: nothing is enqueued.
- s_ready = (count < DEPTH). It is combinational from registered state only, with no dependence on the same-cycle pop.
- Write port (combinational):
  - If primary is effective, grf_a3=p_a3 and grf_wd=p_wd.
  - Else if the FIFO is non-empty, grf_a3 and grf_wd take the head entry, and the head is popped at the clock edge.
  - Else grf_a3=0 and grf_wd=0.
- Minimum secondary latency is 1 cycle: an entry pushed at edge N can drain during the cycle after N. There is no same-cycle bypass.
- Simultaneous push and pop in the same cycle: count is unchanged and FIFO order is preserved.
- WAW squash: when primary is effective, every valid queued entry with a3==p_a3 is invalidated at that edge.
  - Squashed entries still occupy their slot. When a squashed entry reaches the head, it pops silently in a cycle with grf_a3=0 unless the primary is writing.
  - An entry pushed in the same cycle as a matching primary write is NOT squashed. The secondary is younger.
- pend_mask = OR over valid, unsquashed entries of the one-hot(a3). Bit 0 is always 0. It is combinational from registered state.
- Starvation counter starve_cnt:
  - Increments each cycle the FIFO head is valid and not popped.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- stall_req is registered. It goes to 1 at the edge where starve_cnt reaches STARVE_LIMIT, and to 0 at the edge after the head pops. Upstream guarantees p_we=0 in any cycle where stall_req=1.
- If p_we=1 arrives anyway while stall_req=1, the primary still wins. The block neither hangs nor corrupts data.
- Pointers are DEPTH-modulo and wrap around. count ranges 0..DEPTH.
- Reset, including mid-operation: on the next edge all entries are invalid, pointers=0, count=0, starve_cnt=0, stall_req=0. Queued writes are dropped.
- Outputs after reset: grf_a3=0 when p_we=0, grf_wd=0, pend_mask=0, s_ready=1, stall_req=0, fifo_count=0.
- A push presented during reset is ignored.

Test Plan:
1. Reset, then an idle cycle -> grf_a3=0, s_ready=1, pend_mask=0, fifo_count=0.
2. Push s_a3=5, s_wd=0x1234 with p_we=0 -> pend_mask=0x20 after the edge; next cycle grf_a3=5, grf_wd=0x1234; pend_mask=0 after the following edge.
3. Fill 4 entries (r1..r4) while p_we=1 to r9 continuously:
   - s_ready drops to 0 at count=4.
   - grf_a3 stays 9.
   - After 8 waiting cycles stall_req=1.
   - Drop p_we -> r1 drains, and stall_req=0 on the next edge.
4. Queue r7=0xAAAA, then a primary write to r7=0xBBBB -> the entry is squashed, pend_mask bit7 clears, and the later drain cycle shows grf_a3=0 (r7 stays 0xBBBB).
5. Push while popping at count=DEPTH-1 across pointer wrap -> count unchanged, and data drains in FIFO order with correct values.
6. Assert reset with 3 queued entries -> next cycle fifo_count=0, pend_mask=0, stall_req=0, and no queued write ever reaches grf_a3.
